// File: rtl/mem_access_unit.sv
// Memory stage controller: passes ALU results through in one cycle and
// sequences data-memory loads/stores with a stall, a bubble and a timeout.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | accepting a new EX/MEM entry when start_i is high
// S_WAIT | memory request outstanding, waiting for mem_ack_i or timeout
module mem_access_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        RegWrite_i,
    input  logic        MemReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        RegWrite_o,
    output logic        MemReg_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hold_regwrite_q, hold_regwrite_d;
    logic        hold_memreg_q, hold_memreg_d;
    logic        hold_write_q, hold_write_d;
    logic [4:0]  hold_rd_q, hold_rd_d;

    logic        mem_req_d, mem_we_d, err_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic        regwrite_d, memreg_d;
    logic [4:0]  rd_addr_d;
    logic [31:0] data1_d, data2_d;

    logic        mem_op;
    logic        timeout;

    assign mem_op  = MemRead_i | MemWrite_i;
    assign timeout = (state_q == S_WAIT) && !mem_ack_i && (cnt_q == CNT_MAX);

    // The abandoned transaction must not hold the pipeline on its final cycle.
    assign stall_o = ((state_q == S_IDLE) && start_i && mem_op) ||
                     ((state_q == S_WAIT) && !mem_ack_i && !timeout);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        hold_regwrite_d = hold_regwrite_q;
        hold_memreg_d   = hold_memreg_q;
        hold_write_d    = hold_write_q;
        hold_rd_d       = hold_rd_q;
        mem_req_d       = mem_req_o;
        mem_we_d        = mem_we_o;
        mem_addr_d      = mem_addr_o;
        mem_wdata_d     = mem_wdata_o;
        err_d           = err_o;
        regwrite_d      = RegWrite_o;
        memreg_d        = MemReg_o;
        rd_addr_d       = rd_addr_o;
        data1_d         = data1_o;
        data2_d         = data2_o;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (mem_op) begin
                        hold_regwrite_d = RegWrite_i;
                        hold_memreg_d   = MemReg_i;
                        hold_write_d    = MemWrite_i;
                        hold_rd_d       = rd_addr_i;
                        mem_req_d       = 1'b1;
                        mem_we_d        = MemWrite_i;
                        mem_addr_d      = alu_result_i;
                        mem_wdata_d     = wdata_i;
                        cnt_d           = 8'd0;
                        regwrite_d      = 1'b0;
                        memreg_d        = 1'b0;
                        rd_addr_d       = 5'd0;
                        data1_d         = 32'd0;
                        data2_d         = 32'd0;
                        state_d         = S_WAIT;
                    end else begin
                        regwrite_d = RegWrite_i;
                        memreg_d   = MemReg_i;
                        rd_addr_d  = rd_addr_i;
                        data1_d    = 32'd0;
                        data2_d    = alu_result_i;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack_i) begin
                    regwrite_d = hold_regwrite_q;
                    memreg_d   = hold_memreg_q;
                    rd_addr_d  = hold_rd_q;
                    data1_d    = hold_write_q ? 32'd0 : mem_rdata_i;
                    data2_d    = mem_addr_o;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = S_IDLE;
                end else begin
                    regwrite_d = 1'b0;
                    memreg_d   = 1'b0;
                    rd_addr_d  = 5'd0;
                    data1_d    = 32'd0;
                    data2_d    = 32'd0;
                    if (timeout) begin
                        err_d     = 1'b1;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        cnt_d     = 8'd0;
                        state_d   = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            cnt_q           <= 8'd0;
            hold_regwrite_q <= 1'b0;
            hold_memreg_q   <= 1'b0;
            hold_write_q    <= 1'b0;
            hold_rd_q       <= 5'd0;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= 32'd0;
            mem_wdata_o     <= 32'd0;
            err_o           <= 1'b0;
            RegWrite_o      <= 1'b0;
            MemReg_o        <= 1'b0;
            rd_addr_o       <= 5'd0;
            data1_o         <= 32'd0;
            data2_o         <= 32'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            hold_regwrite_q <= hold_regwrite_d;
            hold_memreg_q   <= hold_memreg_d;
            hold_write_q    <= hold_write_d;
            hold_rd_q       <= hold_rd_d;
            mem_req_o       <= mem_req_d;
            mem_we_o        <= mem_we_d;
            mem_addr_o      <= mem_addr_d;
            mem_wdata_o     <= mem_wdata_d;
            err_o           <= err_d;
            RegWrite_o      <= regwrite_d;
            MemReg_o        <= memreg_d;
            rd_addr_o       <= rd_addr_d;
            data1_o         <= data1_d;
            data2_o         <= data2_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random transactions
// checked against a transaction-level expectation of the MEM/WB outputs.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        rw_i = 1'b0, mr_i = 1'b0, mrd_i = 1'b0, mwr_i = 1'b0;
    logic [4:0]  rd_i = 5'd0;
    logic [31:0] alu_i = 32'd0, wd_i = 32'd0;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'd0;

    logic        mem_req, mem_we, stall, err, rw_o, mr_o;
    logic [31:0] mem_addr, mem_wdata, d1_o, d2_o;
    logic [4:0]  rd_o;

    int n_cmp = 0;
    int n_err = 0;

    // expected MEM/WB register contents and sticky error
    logic        e_rw = 1'b0, e_mr = 1'b0, e_err = 1'b0;
    logic [4:0]  e_rd = 5'd0;
    logic [31:0] e_d1 = 32'd0, e_d2 = 32'd0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .RegWrite_i   (rw_i),
        .MemReg_i     (mr_i),
        .MemRead_i    (mrd_i),
        .MemWrite_i   (mwr_i),
        .rd_addr_i    (rd_i),
        .alu_result_i (alu_i),
        .wdata_i      (wd_i),
        .mem_ack_i    (ack),
        .mem_rdata_i  (rdata),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .stall_o      (stall),
        .err_o        (err),
        .RegWrite_o   (rw_o),
        .MemReg_o     (mr_o),
        .rd_addr_o    (rd_o),
        .data1_o      (d1_o),
        .data2_o      (d2_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".RegWrite"}, {31'd0, rw_o}, {31'd0, e_rw});
        chk({tag, ".MemReg"},   {31'd0, mr_o}, {31'd0, e_mr});
        chk({tag, ".rd_addr"},  {27'd0, rd_o}, {27'd0, e_rd});
        chk({tag, ".data1"},    d1_o, e_d1);
        chk({tag, ".data2"},    d2_o, e_d2);
        chk({tag, ".err"},      {31'd0, err},  {31'd0, e_err});
    endtask

    task automatic set_bubble();
        e_rw = 1'b0; e_mr = 1'b0; e_rd = 5'd0; e_d1 = 32'd0; e_d2 = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; start = 1'b1; ack = 1'b1;
        rw_i = 1'b1; mrd_i = 1'b1; alu_i = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0; start = 1'b0; ack = 1'b0;
        set_bubble();
        e_err = 1'b0;
        chk_outs(tag);
        chk({tag, ".mem_req"},   {31'd0, mem_req}, 32'd0);
        chk({tag, ".mem_we"},    {31'd0, mem_we},  32'd0);
        chk({tag, ".mem_addr"},  mem_addr, 32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // One EX/MEM entry presented for one cycle; ack arrives 'delay' WAIT cycles in.
    task automatic op(input string tag, input logic rw, input logic mr, input logic mrd,
                      input logic mwr, input logic [4:0] rd, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rdat, input int delay);
        logic memop;
        memop = mrd | mwr;
        rw_i = rw; mr_i = mr; mrd_i = mrd; mwr_i = mwr;
        rd_i = rd; alu_i = addr; wd_i = wd;
        start = 1'b1; ack = $urandom_range(0, 1) == 1;
        #1;
        chk({tag, ".stall_capture"}, {31'd0, stall}, {31'd0, memop});
        tick();
        start = 1'b0;
        alu_i = $urandom; wd_i = $urandom; rd_i = 5'($urandom_range(0, 31));
        if (!memop) begin
            e_rw = rw; e_mr = mr; e_rd = rd; e_d1 = 32'd0; e_d2 = addr;
            chk({tag, ".stall_after"}, {31'd0, stall}, 32'd0);
        end else begin
            for (int c = 0; c <= delay; c++) begin
                ack = (c == delay);
                rdata = (c == delay) ? rdat : $urandom;
                #1;
                set_bubble();
                chk_outs({tag, ".wait"});
                chk({tag, ".wait.mem_req"},   {31'd0, mem_req}, 32'd1);
                chk({tag, ".wait.mem_we"},    {31'd0, mem_we},  {31'd0, mwr});
                chk({tag, ".wait.mem_addr"},  mem_addr, addr);
                chk({tag, ".wait.mem_wdata"}, mem_wdata, wd);
                chk({tag, ".wait.stall"},     {31'd0, stall}, {31'd0, c != delay});
                tick();
            end
            ack = 1'b0;
            e_rw = rw; e_mr = mr; e_rd = rd;
            e_d1 = mwr ? 32'd0 : rdat;
            e_d2 = addr;
            chk({tag, ".done.mem_req"}, {31'd0, mem_req}, 32'd0);
            chk({tag, ".done.mem_we"},  {31'd0, mem_we},  32'd0);
        end
        chk_outs({tag, ".done"});
    endtask

    // start_i low: outputs hold and stray acks are ignored.
    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            ack = $urandom_range(0, 1) == 1;
            rdata = $urandom;
            mrd_i = $urandom_range(0, 1) == 1;
            rw_i = $urandom_range(0, 1) == 1;
            alu_i = $urandom;
            #1;
            chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
            tick();
            chk_outs(tag);
            chk({tag, ".mem_req"}, {31'd0, mem_req}, 32'd0);
        end
        ack = 1'b0;
    endtask

    initial begin
        tick();
        do_reset("reset");

        op("alu", 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_0010, 32'd0, 32'd0, 0);
        idle("alu_hold", 2);

        op("load", 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 3);
        idle("load_hold", 1);

        op("store", 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0200, 32'h0000_1234, 32'h5555_AAAA, 0);

        op("rw_both", 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0300, 32'hCAFE_0001, 32'h7777_7777, 1);

        for (int t = 0; t < 40; t++) begin
            logic kind_mem, is_wr, is_rd;
            kind_mem = $urandom_range(0, 2) != 0;
            is_wr = kind_mem && ($urandom_range(0, 2) == 0);
            is_rd = kind_mem && (!is_wr || ($urandom_range(0, 3) == 0));
            op("rand", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, is_rd, is_wr,
               5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom_range(0, 6));
            idle("rand_hold", $urandom_range(0, 2));
        end

        // timeout: 256 WAIT cycles without ack
        rw_i = 1'b1; mr_i = 1'b1; mrd_i = 1'b1; mwr_i = 1'b0;
        rd_i = 5'd12; alu_i = 32'h0000_0400; wd_i = 32'd0;
        start = 1'b1; ack = 1'b0;
        #1;
        chk("to.stall_capture", {31'd0, stall}, 32'd1);
        tick();
        start = 1'b0;
        for (int c = 0; c < 256; c++) begin
            #1;
            chk("to.stall", {31'd0, stall}, {31'd0, c != 255});
            chk("to.mem_req", {31'd0, mem_req}, 32'd1);
            chk("to.err_pending", {31'd0, err}, 32'd0);
            tick();
        end
        set_bubble();
        e_err = 1'b1;
        chk_outs("to.done");
        chk("to.done.mem_req", {31'd0, mem_req}, 32'd0);
        idle("to_hold", 1);
        op("after_to_alu", 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'h0000_0044, 32'd0, 32'd0, 0);
        op("after_to_load", 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_0048, 32'd0, 32'h0BAD_F00D, 2);
        do_reset("reset_clears_err");

        // reset in the second WAIT cycle, then a late ack
        rw_i = 1'b1; mr_i = 1'b1; mrd_i = 1'b1; mwr_i = 1'b0;
        rd_i = 5'd20; alu_i = 32'h0000_0500;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rstw.w1.mem_req", {31'd0, mem_req}, 32'd1);
        tick();
        chk("rstw.w2.mem_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_bubble();
        chk_outs("rstw.after");
        chk("rstw.after.mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstw.after.mem_addr", mem_addr, 32'd0);
        for (int i = 0; i < 2; i++) begin
            ack = 1'b1; rdata = 32'hFEED_FACE;
            #1;
            chk("rstw.late.stall", {31'd0, stall}, 32'd0);
            tick();
            chk_outs("rstw.late");
            chk("rstw.late.mem_req", {31'd0, mem_req}, 32'd0);
        end
        ack = 1'b0;

        op("final_alu", 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 32'h8000_0001, 32'd0, 32'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
